// File: rtl/pipeline_ctrl_pkg.sv
// pipe_pkg: pipeline-register control codes and hazard FSM states shared by the pipeline slice.
package pipe_pkg;
    typedef enum logic [1:0] {NORMAL = 2'b00, STALL = 2'b01, FLUSH = 2'b10} ctrl_e;
    typedef enum logic {RUN, REDIRECT_WAIT} state_e;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs from the datapath and control codes back to its pipeline registers.
interface pipeline_ctrl_if #(parameter int REG_ADDR_WIDTH = 5);
    import pipe_pkg::*;
    logic [REG_ADDR_WIDTH-1:0] id_rs1, id_rs2, ex_rd;
    logic ex_mem_read, ex_branch_taken, if_busy, mem_busy, pc_hold;
    ctrl_e ifid_ctrl, idex_ctrl, exmem_ctrl, memwb_ctrl;
    modport master(output id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch_taken, if_busy, mem_busy,
                   input pc_hold, ifid_ctrl, idex_ctrl, exmem_ctrl, memwb_ctrl);
    modport slave(input id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch_taken, if_busy, mem_busy,
                  output pc_hold, ifid_ctrl, idex_ctrl, exmem_ctrl, memwb_ctrl);
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
module sat_counter #(parameter int WIDTH = 16) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (reset || clr) cnt <= '0;
        else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: prioritised stall/flush control for a 5-stage pipeline with performance counters.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 perf_clr,
    pipeline_ctrl_if.slave       p,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] redirect_cnt
);
    state_e state, state_nxt;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic load_use, redirect;
    assign rd = p.ex_rd;
    assign load_use = p.ex_mem_read && rd != '0 && (rd == p.id_rs1 || rd == p.id_rs2);
    always_comb begin
        p.pc_hold    = 1'b0;
        p.ifid_ctrl  = NORMAL;
        p.idex_ctrl  = NORMAL;
        p.exmem_ctrl = NORMAL;
        p.memwb_ctrl = NORMAL;
        state_nxt    = state;
        redirect     = 1'b0;
        if (reset) begin
            p.pc_hold    = 1'b1;
            p.ifid_ctrl  = FLUSH;
            p.idex_ctrl  = FLUSH;
            p.exmem_ctrl = FLUSH;
            p.memwb_ctrl = FLUSH;
            state_nxt    = RUN;
        end else if (p.mem_busy) begin
            p.pc_hold    = 1'b1;
            p.ifid_ctrl  = STALL;
            p.idex_ctrl  = STALL;
            p.exmem_ctrl = STALL;
            p.memwb_ctrl = FLUSH;
        end else if (state == REDIRECT_WAIT) begin
            // stale fetch still outstanding: hold PC until it drains, discarding what arrives
            p.pc_hold   = 1'b1;
            p.ifid_ctrl = FLUSH;
            state_nxt   = p.if_busy ? REDIRECT_WAIT : RUN;
        end else if (p.ex_branch_taken) begin
            p.ifid_ctrl = FLUSH;
            p.idex_ctrl = FLUSH;
            redirect    = 1'b1;
            state_nxt   = p.if_busy ? REDIRECT_WAIT : RUN;
        end else if (load_use) begin
            p.pc_hold   = 1'b1;
            p.ifid_ctrl = STALL;
            p.idex_ctrl = FLUSH;
        end else if (p.if_busy) begin
            p.pc_hold   = 1'b1;
            p.ifid_ctrl = FLUSH;
        end
    end
    always_ff @(posedge clk) state <= state_nxt;
    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall (
        .clk(clk), .reset(reset), .inc(p.pc_hold), .clr(perf_clr), .cnt(stall_cnt)
    );
    sat_counter #(.WIDTH(CNT_WIDTH)) u_redirect (
        .clk(clk), .reset(reset), .inc(redirect), .clr(perf_clr), .cnt(redirect_cnt)
    );
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed hazard scenarios checked with immediate assertions against hand-computed values.
module tb_pipeline_ctrl;
    import pipe_pkg::*;
    logic clk = 1'b0;
    logic reset, perf_clr;
    logic [15:0] stall_cnt, redirect_cnt;
    int total = 0;
    int bad = 0;
    pipeline_ctrl_if #(.REG_ADDR_WIDTH(5)) bus ();
    pipeline_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .perf_clr(perf_clr), .p(bus.slave),
        .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
    );
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs1, rs2, rd, input logic mr, br, ifb, mb);
        bus.id_rs1 = rs1;
        bus.id_rs2 = rs2;
        bus.ex_rd = rd;
        bus.ex_mem_read = mr;
        bus.ex_branch_taken = br;
        bus.if_busy = ifb;
        bus.mem_busy = mb;
        #1;
    endtask

    // expected vector is {pc_hold, ifid, idex, exmem, memwb}
    task automatic chk_out(input string tag, input logic [8:0] exp);
        logic [8:0] got;
        got = {bus.pc_hold, bus.ifid_ctrl, bus.idex_ctrl, bus.exmem_ctrl, bus.memwb_ctrl};
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    localparam logic [8:0] IDLE  = 9'b0_00_00_00_00;
    localparam logic [8:0] RST_O = 9'b1_10_10_10_10;
    localparam logic [8:0] LU_O  = 9'b1_01_10_00_00;
    localparam logic [8:0] BR_O  = 9'b0_10_10_00_00;
    localparam logic [8:0] WAIT_O = 9'b1_10_00_00_00;
    localparam logic [8:0] MEM_O = 9'b1_01_01_01_10;

    initial begin
        reset = 1'b1;
        perf_clr = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk_out("reset_outputs", RST_O);
        tick();
        chk_cnt("reset_stall", stall_cnt, 16'h0);
        chk_cnt("reset_redirect", redirect_cnt, 16'h0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk_out("idle", IDLE);
        tick();
        drive(3, 5, 5, 1, 0, 0, 0);
        chk_out("load_use_rs2", LU_O);
        tick();
        drive(3, 5, 0, 0, 0, 0, 0);
        chk_out("load_use_release", IDLE);
        tick();
        chk_cnt("load_use_stall", stall_cnt, 16'd1);
        drive(0, 7, 0, 1, 0, 0, 0);
        chk_out("load_x0_no_stall", IDLE);
        tick();
        chk_cnt("load_x0_stall", stall_cnt, 16'd1);
        drive(5, 0, 5, 1, 1, 0, 0);
        chk_out("branch_beats_load_use", BR_O);
        tick();
        chk_cnt("branch_redirect", redirect_cnt, 16'd1);
        chk_cnt("branch_no_stall", stall_cnt, 16'd1);
        perf_clr = 1'b1;
        drive(0, 0, 0, 0, 0, 1, 0);
        chk_out("if_busy_alone", WAIT_O);
        tick();
        perf_clr = 1'b0;
        chk_cnt("clr_over_inc_stall", stall_cnt, 16'd0);
        chk_cnt("clr_redirect", redirect_cnt, 16'd0);
        drive(0, 0, 0, 0, 1, 1, 0);
        chk_out("redirect_busy_c0", BR_O);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0);
            chk_out("redirect_wait", WAIT_O);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk_out("redirect_drop", WAIT_O);
        tick();
        chk_out("redirect_back_run", IDLE);
        chk_cnt("redirect_wait_redirect", redirect_cnt, 16'd1);
        chk_cnt("redirect_wait_stall", stall_cnt, 16'd4);
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 1, 0, 1);
            chk_out("mem_busy_freeze", MEM_O);
            tick();
        end
        chk_cnt("mem_busy_no_redirect", redirect_cnt, 16'd0);
        chk_cnt("mem_busy_stall", stall_cnt, 16'd5);
        drive(0, 0, 0, 0, 1, 0, 0);
        chk_out("mem_busy_then_branch", BR_O);
        tick();
        chk_cnt("mem_busy_redirect_taken", redirect_cnt, 16'd1);
        drive(0, 0, 0, 0, 1, 1, 0);
        tick();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 1, 0);
        chk_out("reset_in_wait", RST_O);
        tick();
        chk_cnt("reset_in_wait_stall", stall_cnt, 16'd0);
        chk_out("reset_held", RST_O);
        tick();
        chk_cnt("reset_held_stall", stall_cnt, 16'd0);
        chk_cnt("reset_held_redirect", redirect_cnt, 16'd0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk_out("after_reset_run", IDLE);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 65534; i++) tick();
        chk_cnt("sat_fffe", stall_cnt, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_cnt("sat_ffff", stall_cnt, 16'hFFFF);
        end
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        chk_cnt("sat_clr", stall_cnt, 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter REG_ADDR_WIDTH, default 5, register-index width.
REQ-002 Parameter CNT_WIDTH, default 16, performance-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 id_rs1  input  REG_ADDR_WIDTH  rs1 index of instruction in ID.
REQ-006 id_rs2  input  REG_ADDR_WIDTH  rs2 index of instruction in ID.
REQ-007 ex_rd  input  REG_ADDR_WIDTH  destination index of instruction in EX.
REQ-008 ex_mem_read  input  1  instruction in EX is a load.
REQ-009 ex_branch_taken  input  1  EX resolves taken branch/jump; PC loads target this cycle.
REQ-010 if_busy  input  1  instruction-bus fetch in flight, not yet acknowledged.
REQ-011 mem_busy  input  1  data-bus access in MEM in flight, not yet acknowledged.
REQ-012 perf_clr  input  1  synchronous clear of both counters.
REQ-013 pc_hold  output  1  PC register keeps its value.
REQ-014 ifid_ctrl, idex_ctrl, exmem_ctrl, memwb_ctrl  output  2 each  per-register control code.
REQ-015 stall_cnt  output  CNT_WIDTH  cycles with pc_hold=1.
REQ-016 redirect_cnt  output  CNT_WIDTH  taken redirects accepted.

Function
REQ-017 Control codes SHALL be: 00 NORMAL (load), 01 STALL (hold), 10 FLUSH (load bubble, PC passed through); 11 never driven.
REQ-018 FSM SHALL have states RUN and REDIRECT_WAIT; outputs SHALL be combinational from state and inputs (zero-cycle latency), state registered.
REQ-019 Priority, highest first: mem_busy, REDIRECT_WAIT, ex_branch_taken, load-use, if_busy, none.
REQ-020 mem_busy=1: pc_hold=1, ifid/idex/exmem=STALL, memwb=FLUSH; state unchanged; ex_branch_taken ignored this cycle (EX is frozen, so it re-presents).
REQ-021 Taken branch in RUN, mem_busy=0, if_busy=0: pc_hold=0, ifid=FLUSH, idex=FLUSH, exmem/memwb=NORMAL; redirect_cnt increments; stay RUN.
REQ-022 Taken branch in RUN, mem_busy=0, if_busy=1: same outputs as REQ-021 and redirect_cnt increments, next state REDIRECT_WAIT.
REQ-023 REDIRECT_WAIT: pc_hold=1, ifid=FLUSH, others NORMAL; while if_busy=1 stay; on cycle with if_busy=0 (stale fetch returns) output identical, next state RUN.
REQ-024 Load-use = ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2); when highest active: pc_hold=1, ifid=STALL, idex=FLUSH, exmem/memwb=NORMAL; exactly one bubble since load leaves EX next cycle.
REQ-025 if_busy alone in RUN: pc_hold=1, ifid=FLUSH, others NORMAL.
REQ-026 No condition: pc_hold=0, all codes NORMAL.
REQ-027 stall_cnt SHALL increment each cycle pc_hold=1; both counters SHALL saturate at all-ones, never wrap.
REQ-028 perf_clr=1 SHALL zero both counters that cycle, overriding any increment that cycle.
REQ-029 Branch with ex_rd matching load-use simultaneously: branch wins; no load-use bubble.

Reset
REQ-030 reset=1 at clock edge SHALL set state RUN, stall_cnt=0, redirect_cnt=0, regardless of mid-wait state.
REQ-031 While reset=1, outputs SHALL be pc_hold=1 and all four codes FLUSH; counters do not increment.
REQ-032 First cycle after reset deasserts SHALL evaluate REQ-019 from RUN.

Structure
REQ-033 Package pipe_pkg SHALL hold the control-code enum (NORMAL/STALL/FLUSH) and the FSM state enum; IFIDREG and sibling pipeline registers SHALL import the same code enum.
REQ-034 Counters SHALL use one sub-module sat_counter (parameter WIDTH; inputs inc, clr) instantiated twice.

Verification
REQ-035 Load x5 in EX, ID reads rs2=x5, no busy -> one cycle pc_hold=1, ifid=01, idex=10; next cycle all 00; stall_cnt=1.
REQ-036 Load to x0, ID rs1=x0 -> no stall, all 00.
REQ-037 Branch taken with if_busy=1 for 3 more cycles -> cycle0 ifid=idex=10, pc_hold=0; then 4 cycles pc_hold=1, ifid=10 (incl. if_busy-drop cycle); then RUN; redirect_cnt=1, stall_cnt=4.
REQ-038 mem_busy=1 for 5 cycles with branch asserted -> 5 cycles ifid/idex/exmem=01, memwb=10, redirect_cnt unchanged; redirect taken on cycle 6.
REQ-039 Force stall_cnt to 0xFFFE, hold if_busy 3 cycles -> stall_cnt=0xFFFF, stays; perf_clr pulse -> 0.
REQ-040 reset asserted in REDIRECT_WAIT -> during reset pc_hold=1, all codes 10; after release state RUN, counters 0.
